// File: rtl/afifo_pkg.sv
// Shared async-FIFO definitions: default sizes, occupancy type, Gray decode
// and the read-level width helper.
package afifo_pkg;

  localparam int ADDRSIZE_DEF = 4;
  localparam int DATASIZE_DEF = 8;

  typedef logic [1:0] occ_t;
  localparam occ_t OCC_EMPTY = 2'd0;
  localparam occ_t OCC_FULL  = 2'd2;

  // Level covers 2^ADDRSIZE memory words plus two buffered words.
  function automatic int level_width(input int addrsize);
    return addrsize + 2;
  endfunction

  // bin[i] is the XOR of all Gray bits at or above i; callers zero-extend.
  function automatic logic [31:0] gray_to_bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int unsigned s = 1; s < 32; s++) begin
      b = b ^ (g >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/rfifo_fwft_out_if.sv
// Valid/ready output stream of the read-side FWFT stage.
interface rfifo_fwft_out_if
  import afifo_pkg::*;
#(
  parameter int DATASIZE = DATASIZE_DEF
) ();
  logic                out_valid;
  logic [DATASIZE-1:0] out_data;
  logic                out_ready;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/rfifo_fwft_out_gray2bin.sv
// Combinational Gray-to-binary converter of parameterized width.
module gray2bin
  import afifo_pkg::*;
#(
  parameter int W = ADDRSIZE_DEF + 1
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);
  assign bin_o = W'(gray_to_bin(32'(gray_i)));
endmodule

// File: rtl/rfifo_fwft_out.sv
// Read-side output stage: 2-entry first-word-fall-through buffer fed from the
// FIFO memory read port, plus registered read-side occupancy.
module rfifo_fwft_out
  import afifo_pkg::*;
#(
  parameter int ADDRSIZE = ADDRSIZE_DEF,
  parameter int DATASIZE = DATASIZE_DEF
) (
  input  logic                             rclk,
  input  logic                             rrst_n,
  input  logic                             rempty,
  input  logic [ADDRSIZE:0]                rptr,
  input  logic [ADDRSIZE:0]                rq2_wptr,
  input  logic [DATASIZE-1:0]              rdata,
  output logic                             rinc,
  rfifo_fwft_out_if.master                 rd_stream,
  output logic [level_width(ADDRSIZE)-1:0] rlevel
);
  localparam int LVL_W = level_width(ADDRSIZE);

  occ_t                occ_q, occ_d;
  logic [DATASIZE-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [LVL_W-1:0]    rlevel_q, rlevel_d;
  logic [ADDRSIZE:0]   rbin, wbin, mem_lvl;
  logic                pop;

  gray2bin #(.W(ADDRSIZE + 1)) u_rbin (.gray_i(rptr),     .bin_o(rbin));
  gray2bin #(.W(ADDRSIZE + 1)) u_wbin (.gray_i(rq2_wptr), .bin_o(wbin));

  // Fetch depends only on registered state, never on out_ready.
  assign rinc = ~rempty & (occ_q != OCC_FULL);
  assign pop  = (occ_q != OCC_EMPTY) & rd_stream.out_ready;

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    occ_d = occ_q;
    unique case ({pop, rinc})
      2'b10: begin
        e0_d  = e1_q;
        occ_d = occ_q - 2'd1;
      end
      2'b01: begin
        if (occ_q == OCC_EMPTY) e0_d = rdata;
        else                    e1_d = rdata;
        occ_d = occ_q + 2'd1;
      end
      2'b11: begin
        if (occ_q == OCC_FULL) begin
          e0_d = e1_q;
          e1_d = rdata;
        end else begin
          e0_d = rdata;
        end
      end
      default: ;
    endcase
  end

  // Modular subtraction absorbs pointer wrap-around.
  assign mem_lvl  = wbin - rbin;
  assign rlevel_d = LVL_W'(mem_lvl) + LVL_W'(occ_d);

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      occ_q    <= OCC_EMPTY;
      e0_q     <= '0;
      e1_q     <= '0;
      rlevel_q <= '0;
    end else begin
      occ_q    <= occ_d;
      e0_q     <= e0_d;
      e1_q     <= e1_d;
      rlevel_q <= rlevel_d;
    end
  end

  assign rd_stream.out_valid = (occ_q != OCC_EMPTY);
  assign rd_stream.out_data  = e0_q;
  assign rlevel              = rlevel_q;

endmodule

// File: tb/tb_rfifo_fwft_out.sv
// Scoreboard bench: a behavioural read-pointer block and memory feed the DUT;
// a negedge monitor checks delivered words, stalls and fetch gating.
module tb_rfifo_fwft_out;

  logic       rclk = 1'b0;
  logic       rrst_n;
  logic       rempty;
  logic [4:0] rptr, rq2_wptr;
  logic [7:0] rdata;
  logic       rinc;
  logic [5:0] rlevel;

  rfifo_fwft_out_if #(.DATASIZE(8)) sif ();

  rfifo_fwft_out #(.ADDRSIZE(4), .DATASIZE(8)) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rempty    (rempty),
    .rptr      (rptr),
    .rq2_wptr  (rq2_wptr),
    .rdata     (rdata),
    .rinc      (rinc),
    .rd_stream (sif.master),
    .rlevel    (rlevel)
  );

  always #5 rclk = ~rclk;

  logic [7:0] mem [16];
  logic [4:0] rbin, wbin;
  logic       ptr_load;
  logic [4:0] ptr_load_val;
  int         occ_m;
  logic [7:0] exp_q [$];
  int         n_checks = 0;
  int         n_fail   = 0;

  function automatic logic [4:0] bin2gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  assign rempty   = !rrst_n || ptr_load || (rbin == wbin);
  assign rptr     = bin2gray(rbin);
  assign rq2_wptr = bin2gray(wbin);
  assign rdata    = mem[rbin[3:0]];

  always @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) rbin <= '0;
    else if (rinc) rbin <= rbin + 5'd1;
    else if (ptr_load) rbin <= ptr_load_val;
  end

  // Independent buffer-occupancy model.
  always @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) occ_m <= 0;
    else occ_m <= occ_m + (rinc ? 1 : 0) - (((occ_m != 0) && sif.out_ready) ? 1 : 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = '0;
  logic [7:0] exp_w;

  always @(negedge rclk) begin
    if (!rrst_n) begin
      prev_stall = 1'b0;
    end else begin
      check("rinc_gate", 32'(rinc), 32'(!rempty && occ_m < 2));
      check("valid_occ", 32'(sif.out_valid), 32'(occ_m != 0));
      if (prev_stall) begin
        check("stall_valid", 32'(sif.out_valid), 32'd1);
        check("stall_data", 32'(sif.out_data), 32'(prev_data));
      end
      if (sif.out_valid && sif.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_underflow: got word %0h, expected none at %0t", sif.out_data, $time);
        end else begin
          exp_w = exp_q.pop_front();
          check("sb_data", 32'(sif.out_data), 32'(exp_w));
        end
      end
      prev_stall = sif.out_valid && !sif.out_ready;
      prev_data  = sif.out_data;
    end
  end

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic write_word(input logic [7:0] v);
    mem[wbin[3:0]] = v;
    wbin = wbin + 5'd1;
    exp_q.push_back(v);
  endtask

  task automatic drain(input string name);
    sif.out_ready = 1'b1;
    for (int i = 0; i < 300 && !(exp_q.size() == 0 && !sif.out_valid && rempty); i++) tick();
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    int written;
    rrst_n        = 1'b0;
    sif.out_ready = 1'b0;
    wbin          = '0;
    ptr_load      = 1'b0;
    ptr_load_val  = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    tick();
    tick();
    check("rst_valid", 32'(sif.out_valid), 32'd0);
    check("rst_data", 32'(sif.out_data), 32'd0);
    check("rst_level", 32'(rlevel), 32'd0);
    check("rst_rinc", 32'(rinc), 32'd0);
    rrst_n = 1'b1;
    tick();

    // Single word held under backpressure.
    write_word(8'hA5);
    #1;
    check("single_rinc", 32'(rinc), 32'd1);
    tick();
    check("single_valid", 32'(sif.out_valid), 32'd1);
    check("single_data", 32'(sif.out_data), 32'hA5);
    check("single_rinc_off", 32'(rinc), 32'd0);
    repeat (3) tick();
    check("single_level", 32'(rlevel), 32'd1);
    sif.out_ready = 1'b1;
    tick();
    sif.out_ready = 1'b0;
    check("single_popped", 32'(sif.out_valid), 32'd0);
    tick();

    // Sixteen-word stream with ready held high.
    sif.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) write_word(8'(i));
    cnt = 0;
    repeat (20) begin
      @(negedge rclk);
      if (sif.out_valid) cnt++;
    end
    check("stream_valid_cycles", 32'(cnt), 32'd16);
    drain("stream_drain");

    // Backpressure: eight words, ready low for ten cycles.
    tick();
    sif.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) write_word(8'h80 + 8'(i));
    cnt = 0;
    repeat (10) begin
      @(negedge rclk);
      if (rinc) cnt++;
    end
    check("bp_rinc_pulses", 32'(cnt), 32'd2);
    check("bp_occ", 32'(occ_m), 32'd2);
    check("bp_level", 32'(rlevel), 32'd8);
    drain("bp_drain");

    // Pointer wrap: read pointer at 30, write pointer lands on 2.
    tick();
    sif.out_ready = 1'b0;
    ptr_load      = 1'b1;
    ptr_load_val  = 5'd30;
    wbin          = 5'd30;
    tick();
    ptr_load = 1'b0;
    for (int i = 0; i < 4; i++) write_word(8'hC0 + 8'(i));
    tick();
    check("wrap_level_first", 32'(rlevel), 32'd5);
    repeat (3) tick();
    check("wrap_level_settled", 32'(rlevel), 32'd4);
    drain("wrap_drain");

    // Reset while the buffer is full.
    tick();
    sif.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) write_word(8'h50 + 8'(i));
    repeat (4) tick();
    check("prerst_valid", 32'(sif.out_valid), 32'd1);
    rrst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(sif.out_valid), 32'd0);
    check("midrst_data", 32'(sif.out_data), 32'd0);
    check("midrst_level", 32'(rlevel), 32'd0);
    exp_q.delete();
    wbin = '0;
    tick();
    rrst_n = 1'b1;
    repeat (3) begin
      @(negedge rclk);
      check("postrst_rinc", 32'(rinc), 32'd0);
    end
    tick();

    // Random ready over 1000 words.
    written = 0;
    for (int c = 0; c < 20000 && written < 1000; c++) begin
      sif.out_ready = 1'($urandom_range(0, 1));
      if ((wbin - rbin) < 5'd16 && $urandom_range(0, 3) != 0) begin
        write_word(8'($urandom_range(0, 255)));
        written++;
      end
      tick();
    end
    check("rand_written", 32'(written), 32'd1000);
    drain("rand_drain");

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
